// File: rtl/divider_pkg.sv
// Shared state encodings and FSM state type for the restoring divider.
package divider_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract on W+1 bits.
module div_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // The partial remainder stays below the divisor, so the shifted value is below
  // twice the divisor and the MSB of the W+1-bit difference is its sign.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[W];
    rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle, MSB first.
// Define DIV_ZERO_EN to add the div_zero flag and a single-cycle zero-divisor shortcut.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef DIV_ZERO_EN
  output logic         div_zero,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  step_rem;
  logic          step_q;
`ifdef DIV_ZERO_EN
  logic          dz_q, dz_d;
`endif

  div_step #(.W(W)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[cnt_q]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
`ifdef DIV_ZERO_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          cnt_d   = CW'(W - 1);
          rem_d   = '0;
          state_d = BUSY;
`ifdef DIV_ZERO_EN
          dz_d = 1'b0;
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = {quo_q[W-2:0], step_q};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
`ifdef DIV_ZERO_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
`ifdef DIV_ZERO_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef DIV_ZERO_EN
  assign div_zero  = dz_q;
`endif

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter W, default 4: operand and result width in bits, unsigned, W >= 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair present.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port dividend  input  W  unsigned dividend.
REQ-007 SHALL have port divisor  input  W  unsigned divisor.
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port quotient  output  W  unsigned quotient.
REQ-011 SHALL have port remainder  output  W  unsigned remainder.
REQ-012 SHALL have port div_zero  output  1  divisor was zero; present only when DIV_ZERO_EN is defined.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 SHALL capture dividend and divisor on any edge with in_valid&&in_ready, load step counter with W-1 and zero the partial remainder, then move IDLE->BUSY.
REQ-016 SHALL perform one restoring step per BUSY cycle, MSB first: shift {rem,dividend bit} left, subtract divisor on W+1 bits, keep difference and set quotient bit to 1 if non-negative, else restore and set it to 0.
REQ-017 SHALL move BUSY->DONE on the edge executing step 0, so out_valid is first high exactly W cycles after the accepting edge.
REQ-018 SHALL hold quotient, remainder and out_valid stable in DONE while out_ready=0, for any number of cycles.
REQ-019 SHALL move DONE->IDLE on an edge with out_ready=1; in_ready rises the following cycle, with no same-cycle turnaround.
REQ-020 SHALL ignore in_valid and input operand changes in BUSY and DONE.
REQ-021 SHALL ignore out_ready in IDLE and BUSY.
REQ-022 SHALL, with divisor=0 and DIV_ZERO_EN undefined, run the normal W-cycle sequence, producing quotient=all ones and remainder=dividend.
REQ-023 SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for every nonzero divisor, including dividend=0 and dividend=2^W-1.

Reset
REQ-024 SHALL, on a clk edge with rst_n=0, enter IDLE and clear quotient, remainder, step counter, captured operands and div_zero to 0.
REQ-025 SHALL, when rst_n=0 in BUSY or DONE, abandon the operation with no result produced; in_ready=1 the cycle after the reset edge.
REQ-026 SHALL treat reset as taking priority over any simultaneous handshake.

Configuration
REQ-027 SHALL, with macro DIV_ZERO_EN defined, add port div_zero; a zero divisor at acceptance goes IDLE->DONE on the next edge (latency 1) with quotient=all ones, remainder=dividend, div_zero=1; div_zero is 0 for all other results.
REQ-028 SHALL, without DIV_ZERO_EN, have no div_zero port and follow REQ-022.

Structure
REQ-029 SHALL take the FSM state enum type and the state encodings from shared package divider_pkg.
REQ-030 SHALL place the W+1-bit compare/subtract step in combinational sub-module div_step, parameterized by W and instantiated once.

Verification
REQ-031 SHALL cover: W=4, 13/3 accepted, out_ready=1 -> out_valid high after 4 cycles, quotient=4, remainder=1.
REQ-032 SHALL cover: W=4, 15/1 then 0/5 back-to-back -> 15 r0, then 0 r0; in_ready low during each operation.
REQ-033 SHALL cover: W=4, 5/7 with out_ready low 6 cycles -> quotient=0, remainder=5 held stable; IDLE one cycle after out_ready=1.
REQ-034 SHALL cover: W=4, 9/0 -> without DIV_ZERO_EN, 15 r9 after 4 cycles; with DIV_ZERO_EN, 15 r9 and div_zero=1 after 1 cycle.
REQ-035 SHALL cover: rst_n=0 on BUSY step 2 of 11/2 -> no out_valid, outputs 0, in_ready=1 next cycle; then 11/2 -> 5 r1.
REQ-036 SHALL cover: W=8 random 1000 pairs, nonzero divisor -> match the reference model of REQ-023 with latency exactly 8.
